// File: rtl/pulse_hs_pkg.sv
// pulse_hs_pkg: shared FSM state encoding and handshake mode constants
// for the multi-channel pulse handshake transmitter.
package pulse_hs_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_e;

    localparam int MODE_4PH = 0;
    localparam int MODE_2PH = 1;

endpackage

// File: rtl/pulse_hs_tx_chan.sv
// pulse_hs_tx_chan: one transmitter channel with ack synchroniser, pending
// event counter and req/ack handshake FSM; all outputs come from flops or registered state.
module pulse_hs_tx_chan
    import pulse_hs_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = MODE_4PH
) (
    input  logic             clk1,
    input  logic             rst1,
    input  logic             sin_i,
    input  logic             ovf_clr_i,
    input  logic             ack_i,
    output logic             req_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             overflow_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   req_q, done_q;
    logic                   ack_s, launch, full;
    state_e                 state_q;

    assign ack_s = sync_q[SYNC_STAGES-1];

    // A pulse arriving in the launch cycle replaces the launched event, so the count holds.
    always_comb begin
        launch = (state_q == IDLE) && (cnt_q != '0);
        full   = &cnt_q;
        cnt_d  = launch ? (sin_i ? cnt_q : cnt_q - 1'b1)
                        : ((sin_i && !full) ? cnt_q + 1'b1 : cnt_q);
        ovf_d  = (sin_i && full && !launch) || (ovf_q && !ovf_clr_i);
    end

    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (launch) begin
                    state_q <= REQ;
                    req_q   <= (MODE == MODE_2PH) ? !req_q : 1'b1;
                end
                REQ: if ((MODE == MODE_2PH) ? (ack_s == req_q) : ack_s) begin
                    state_q <= (MODE == MODE_2PH) ? IDLE : WAIT_LOW;
                    req_q   <= (MODE == MODE_2PH) ? req_q : 1'b0;
                    done_q  <= 1'b1;
                end
                WAIT_LOW: if (!ack_s) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_o      = req_q;
    assign done_o     = done_q;
    assign pending_o  = cnt_q;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q != IDLE) || (cnt_q != '0);

endmodule

// File: rtl/pulse_hs_tx_mc.sv
// pulse_hs_tx_mc: multi-channel source-side pulse handshake transmitter;
// independent channels, no arbitration, outputs packed per channel.
module pulse_hs_tx_mc
    import pulse_hs_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = MODE_4PH
) (
    input  logic                      clk1,
    input  logic                      rst1,
    input  logic [CHANNELS-1:0]       sin,
    input  logic                      ovf_clr,
    input  logic [CHANNELS-1:0]       ack_in,
    output logic [CHANNELS-1:0]       req_out,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS*CNT_W-1:0] pending,
    output logic [CHANNELS-1:0]       overflow
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pulse_hs_tx_chan #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES),
            .MODE       (MODE)
        ) u_chan (
            .clk1      (clk1),
            .rst1      (rst1),
            .sin_i     (sin[c]),
            .ovf_clr_i (ovf_clr),
            .ack_i     (ack_in[c]),
            .req_o     (req_out[c]),
            .busy_o    (busy[c]),
            .done_o    (done[c]),
            .pending_o (pending[c*CNT_W +: CNT_W]),
            .overflow_o(overflow[c])
        );
    end

endmodule
